// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
// Types, constants and helpers shared by the stepper phase driver.
//   state_e      : driver FSM states (IDLE, RUN, DONE)
//   DIR_FWD/REV  : cmd_dir encoding (0 = phase index +1, 1 = phase index -1)
//   PHASE_W      : width of the rotating phase index
//   phase_onehot : phase index -> one-hot coil drive
// -----------------------------------------------------------------------------
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int unsigned PHASE_W = 2;

    function automatic logic [3:0] phase_onehot(input logic [PHASE_W-1:0] code);
        phase_onehot = 4'b0001 << code;
    endfunction

endpackage

// File: rtl/stepper_phase_driver_prescaler.sv
// -----------------------------------------------------------------------------
// step_prescaler
// Free-running step-period counter used by the stepper phase driver.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   clr   : synchronous clear (wins over en); suppresses tick
//   en    : count enable
//   tick  : high for the cycle in which the count sits at STEP_DIV-1 while
//           enabled; the counter wraps to 0 on that edge
// Parameter STEP_DIV (>= 2) is the period in clock cycles.
// -----------------------------------------------------------------------------
module step_prescaler #(
    parameter int unsigned STEP_DIV = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_TERM) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stepper_phase_driver.sv
// -----------------------------------------------------------------------------
// stepper_phase_driver
// Full-step driver for a 4-phase unipolar stepper. Accepts a step count and
// direction through a valid/ready handshake, then advances a 2-bit phase index
// once every STEP_DIV cycles and decodes it to one-hot coil drive.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   cmd_valid  : command offered
//   cmd_ready  : command can be accepted (IDLE and no stop)
//   cmd_steps  : steps to run, 0..3 (0 = accepted and discarded)
//   cmd_dir    : 0 = forward (+1), 1 = reverse (-1)
//   stop       : synchronous abort, level-sampled
//   phases     : one-hot coil drive, phases[phase_code] = 1
//   phase_code : current phase index
//   busy       : motion in progress (RUN or DONE)
//   done       : single-cycle pulse at normal completion
// Build option STEPPER_IDLE_RELEASE_EN: coils are de-energised (phases = 0000)
// while IDLE; phase_code still keeps the last position.
// -----------------------------------------------------------------------------
module stepper_phase_driver
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_DIV = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_steps,
    input  logic               cmd_dir,
    input  logic               stop,
    output logic [3:0]         phases,
    output logic [PHASE_W-1:0] phase_code,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [1:0]         remaining_q, remaining_d;
    logic               dir_q, dir_d;

    logic               pre_clr;
    logic               pre_en;
    logic               step_tick;

    // Counter only runs in RUN; holding it clear elsewhere also provides the
    // clear-on-acceptance, and stop clears it on the abort edge.
    assign pre_en  = (state_q == RUN);
    assign pre_clr = (state_q != RUN) || stop;

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (step_tick)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        cmd_ready   = (state_q == IDLE) && !stop;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready && (cmd_steps != 2'd0)) begin
                    remaining_d = cmd_steps;
                    dir_d       = cmd_dir;
                    state_d     = RUN;
                end
            end
            RUN: begin
                // stop takes priority over a coinciding step: no partial step.
                if (stop) begin
                    state_d = IDLE;
                end else if (step_tick) begin
                    case (dir_q)
                        DIR_FWD: phase_d = phase_q + 1'b1;
                        DIR_REV: phase_d = phase_q - 1'b1;
                    endcase
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == 2'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            remaining_q <= '0;
            dir_q       <= DIR_FWD;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
        end
    end

    assign phase_code = phase_q;

`ifdef STEPPER_IDLE_RELEASE_EN
    assign phases = (state_q == IDLE) ? 4'b0000 : phase_onehot(phase_q);
`else
    assign phases = phase_onehot(phase_q);
`endif

endmodule

// File: tb/tb_stepper_phase_driver.sv
module tb_stepper_phase_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_steps;
    logic       cmd_dir;
    logic       stop;
    logic [3:0] phases;
    logic [1:0] phase_code;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    int model_phase = 0;
    int last_pc = 0;

    typedef struct {
        bit is_done;
        int ph;
        int at;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;

    stepper_phase_driver #(
        .STEP_DIV (DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .stop       (stop),
        .phases     (phases),
        .phase_code (phase_code),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    function automatic int idle_phases(input int ph);
`ifdef STEPPER_IDLE_RELEASE_EN
        return 0;
`else
        return 1 << ph;
`endif
    endfunction

    // Monitor: every phase change and every done pulse must match the next
    // expected event (kind, edge number, position).
    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                last_pc = 0;
                continue;
            end
            if (int'(phase_code) != last_pc) begin
                last_pc = int'(phase_code);
                if (exp_q.size() == 0) begin
                    check("unexpected_step_at_edge", edge_cnt, -1);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("step_kind", 0, int'(mon_ev.is_done));
                    check("step_edge", edge_cnt, mon_ev.at);
                    check("step_phase_code", int'(phase_code), mon_ev.ph);
                    check("step_phases", int'(phases), 1 << mon_ev.ph);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done_at_edge", edge_cnt, -1);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("done_kind", 1, int'(mon_ev.is_done));
                    check("done_edge", edge_cnt, mon_ev.at);
                    check("done_phase_code", int'(phase_code), mon_ev.ph);
                end
            end
        end
    end

    // One command: steps land at E0+k*DIV, done shows with the last step;
    // an event at edge t happens only if t precedes the stop edge.
    task automatic issue(input int steps, input int dir, input int stop_after);
        int  e0;
        int  s;
        int  last;
        int  ph;
        int  guard;
        bit  busy_ok;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_cmd", int'(cmd_ready), 1);
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_steps = 2'(steps);
        cmd_dir   = (dir != 0);
        e0 = edge_cnt + 1;
        s  = (stop_after > 0) ? e0 + stop_after : 32'h7fffffff;
        ph = model_phase;
        for (int k = 1; k <= steps; k++) begin
            if (e0 + k * DIV < s) begin
                ph = (ph + ((dir != 0) ? 3 : 1)) % 4;
                exp_q.push_back('{is_done: 1'b0, ph: ph, at: e0 + k * DIV});
            end
        end
        if (steps != 0 && e0 + steps * DIV < s)
            exp_q.push_back('{is_done: 1'b1, ph: ph, at: e0 + steps * DIV});
        model_phase = ph;
        if (steps == 0) last = e0;
        else last = (e0 + steps * DIV + 1 < s) ? e0 + steps * DIV + 1 : s;

        busy_ok = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (edge_cnt < last) begin
            if (!busy || cmd_ready) busy_ok = 1'b0;
            stop = (edge_cnt == s - 1);
            @(negedge clk);
        end
        stop = 1'b0;
        #1;
        check("busy_window", int'(busy_ok), 1);
        check("after_busy", int'(busy), 0);
        check("after_ready", int'(cmd_ready), 1);
        check("after_done", int'(done), 0);
        check("after_phase_code", int'(phase_code), model_phase);
        check("after_phases", int'(phases), idle_phases(model_phase));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int sa;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_steps = 2'd0;
        cmd_dir   = 1'b0;
        stop      = 1'b0;
        #1;
        check("rst_phases_async", int'(phases), idle_phases(0));
        check("rst_phase_code_async", int'(phase_code), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_phases", int'(phases), idle_phases(0));
        check("rst_phase_code", int'(phase_code), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 1);

        issue(3, 0, 0);     // 00 -> 01 -> 10 -> 11
        issue(1, 0, 0);     // 11 -> 00 forward wrap
        issue(2, 1, 0);     // 00 -> 11 -> 10 reverse wrap
        issue(3, 0, 6);     // stop at E6: one step only, no done
        issue(1, 0, 0);     // resumes from the held position

        // Asynchronous reset between edges in the middle of a move.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_steps = 2'd3;
        cmd_dir   = 1'b0;
        exp_q.push_back('{is_done: 1'b0, ph: (model_phase + 1) % 4, at: edge_cnt + 1 + DIV});
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (DIV + 1) @(negedge clk);
        check("pre_reset_step_seen", exp_q.size(), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrun_rst_phases", int'(phases), idle_phases(0));
        check("midrun_rst_phase_code", int'(phase_code), 0);
        check("midrun_rst_busy", int'(busy), 0);
        check("midrun_rst_done", int'(done), 0);
        check("midrun_rst_ready", int'(cmd_ready), 1);
        exp_q.delete();
        model_phase = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        issue(0, 0, 0);     // zero-step command: accepted, no motion

        // stop in IDLE blocks a simultaneous command.
        @(negedge clk);
        stop      = 1'b1;
        cmd_valid = 1'b1;
        cmd_steps = 2'd2;
        #1;
        check("stop_idle_ready", int'(cmd_ready), 0);
        @(negedge clk);
        check("stop_idle_busy", int'(busy), 0);
        stop      = 1'b0;
        cmd_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            st = int'($urandom_range(0, 3));
            sa = 0;
            if (st != 0 && $urandom_range(0, 2) == 0)
                sa = int'($urandom_range(1, 4 * st + 1));
            issue(st, int'($urandom_range(0, 1)), sa);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
